// File: rtl/line_port_arbiter.sv
// Three-master arbiter for the 256-bit line port to the eviction write buffer.
// Fixed priority D > I > PF, non-preemptive, with an I-cache anti-starvation override.
module line_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int OFFSET_W   = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              pf_read,
    input  logic [ADDR_W-1:0] pf_address,
    output logic [LINE_W-1:0] pf_rdata,
    output logic              pf_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [1:0]        grant
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIMIT = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] OFFSET_MASK  = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        BUSY_P = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  starve_cnt_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [LINE_W-1:0] mem_wdata_reg;

    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [LINE_W-1:0] sel_wdata;
    logic [2:0]        owner;
    logic [2:0]        resp_vec;
    logic [LINE_W-1:0] rdata_arr [3];
    logic              d_req;
    logic              i_force;
    logic              grant_edge;

    assign d_req      = d_read | d_write;
    assign i_force    = i_read && (starve_cnt_reg == STARVE_LIMIT);
    assign grant_edge = (state_reg == IDLE) && (state_next != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_force)       state_next = BUSY_I;
                else if (d_req)    state_next = BUSY_D;
                else if (i_read)   state_next = BUSY_I;
                else if (pf_read)  state_next = BUSY_P;
            end
            default: begin
                if (mem_resp) state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        grant = 2'd0;
        owner = 3'b000;
        case (state_reg)
            BUSY_D: begin grant = 2'd1; owner = 3'b001; end
            BUSY_I: begin grant = 2'd2; owner = 3'b010; end
            BUSY_P: begin grant = 2'd3; owner = 3'b100; end
            default: ;
        endcase
    end

    // Request of the master about to be granted; a simultaneous D read+write is a write.
    always_comb begin
        sel_read    = 1'b0;
        sel_write   = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        case (state_next)
            BUSY_D: begin
                sel_write   = d_write;
                sel_read    = d_read & ~d_write;
                sel_address = d_address;
                sel_wdata   = d_wdata;
            end
            BUSY_I: begin
                sel_read    = 1'b1;
                sel_address = i_address;
            end
            BUSY_P: begin
                sel_read    = 1'b1;
                sel_address = pf_address;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
        end else if (grant_edge) begin
            mem_read_reg    <= sel_read;
            mem_write_reg   <= sel_write;
            mem_address_reg <= sel_address & ~OFFSET_MASK;
            mem_wdata_reg   <= sel_wdata;
        end else if ((state_reg != IDLE) && mem_resp) begin
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
        end
    end

    // Counts D grants made over a waiting I-cache; I is forced once it saturates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (state_next == BUSY_I || !i_read) begin
                starve_cnt_reg <= '0;
            end else if (state_next == BUSY_D && starve_cnt_reg != STARVE_LIMIT) begin
                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            assign resp_vec[gi]  = owner[gi] & mem_resp;
            assign rdata_arr[gi] = owner[gi] ? mem_rdata : '0;
        end
    endgenerate

    assign d_resp      = resp_vec[0];
    assign i_resp      = resp_vec[1];
    assign pf_resp     = resp_vec[2];
    assign d_rdata     = rdata_arr[0];
    assign i_rdata     = rdata_arr[1];
    assign pf_rdata    = rdata_arr[2];
    assign mem_read    = mem_read_reg;
    assign mem_write   = mem_write_reg;
    assign mem_address = mem_address_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule
